// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one WIDTH x WIDTH product over WIDTH
// cycles, unsigned or two's-complement per transaction, valid/ready on both sides.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Signed_Mode,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             sign;

  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [PW-1:0]    partial_c;
  logic [PW-1:0]    sum_c;

  // Operand magnitudes and the single shift-add adder
  always_comb begin
    mag_a_c   = (Signed_Mode && A[WIDTH-1]) ? WIDTH'(~A + WIDTH'(1)) : A;
    mag_b_c   = (Signed_Mode && B[WIDTH-1]) ? WIDTH'(~B + WIDTH'(1)) : B;
    accept_c  = (state == S_IDLE) && In_Valid;
    last_c    = (state == S_BUSY) && (count == CW'(1));
    partial_c = mplier[0] ? mcand : '0;
    sum_c     = acc + partial_c;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (In_Valid) state_next = S_BUSY;
      S_BUSY:  if (count == CW'(1)) state_next = S_DONE;
      S_DONE:  if (Out_Ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Handshake/status flags registered from the next state so they track state exactly
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      In_Ready  <= (state_next == S_IDLE);
      Out_Valid <= (state_next == S_DONE);
      Busy      <= (state_next != S_IDLE);
    end
  end

  // Datapath: latch magnitudes on accept, one shift-add step per BUSY cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      sign    <= 1'b0;
      Product <= '0;
    end else if (accept_c) begin
      mcand  <= PW'(mag_a_c);
      mplier <= mag_b_c;
      acc    <= '0;
      count  <= CW'(WIDTH);
      sign   <= Signed_Mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state == S_BUSY) begin
      acc    <= sum_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (last_c) Product <= sign ? PW'(~sum_c + PW'(1)) : sum_c;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed table plus corner sequences on a WIDTH=4 instance,
// and directed/random transactions with output stalls on a WIDTH=8 instance.
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  logic       iv4, ir4, sm4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int tests_run;
  int tests_failed;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .In_Valid(iv4), .In_Ready(ir4), .A(a4), .B(b4),
    .Signed_Mode(sm4), .Out_Valid(ov4), .Out_Ready(or4), .Product(p4), .Busy(busy4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .In_Valid(iv8), .In_Ready(ir8), .A(a8), .B(b8),
    .Signed_Mode(sm8), .Out_Valid(ov8), .Out_Ready(or8), .Product(p8), .Busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One WIDTH=4 transaction with an always-ready consumer; optional operand churn
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] exp, input bit churn, input string name);
    logic early;
    check({name, "_in_ready_pre"}, 32'(ir4), 32'd1);
    a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check({name, "_in_ready_busy"}, 32'(ir4), 32'd0);
    check({name, "_busy"}, 32'(busy4), 32'd1);
    early = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (churn) begin
        a4 = 4'($urandom()); b4 = 4'($urandom()); sm4 = 1'($urandom());
      end
      tick();
      if (ov4 !== 1'b0) early = 1'b1;
    end
    if (churn) begin
      a4 = 4'($urandom()); b4 = 4'($urandom()); sm4 = 1'($urandom());
    end
    tick();
    check({name, "_no_early_valid"}, 32'(early), 32'd0);
    check({name, "_valid_at_W"}, 32'(ov4), 32'd1);
    check({name, "_product"}, 32'(p4), 32'(exp));
    tick();
    check({name, "_valid_after_handoff"}, 32'(ov4), 32'd0);
    check({name, "_in_ready_after_handoff"}, 32'(ir4), 32'd1);
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int sa;
    int sb;
    sa = sm ? int'($signed(a)) : int'(a);
    sb = sm ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  // One WIDTH=8 transaction with a given number of stall cycles after Out_Valid
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input int stall, input string name);
    logic early;
    logic moved;
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1; or8 = 1'b0;
    tick();
    iv8 = 1'b0;
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (ov8 !== 1'b0) early = 1'b1;
    end
    tick();
    check({name, "_no_early_valid"}, 32'(early), 32'd0);
    check({name, "_valid_at_W"}, 32'(ov8), 32'd1);
    check({name, "_product"}, 32'(p8), 32'(exp));
    moved = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      if (ov8 !== 1'b1 || p8 !== exp || ir8 !== 1'b0) moved = 1'b1;
    end
    if (stall > 0) check({name, "_stall_stable"}, 32'(moved), 32'd0);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    check({name, "_handoff"}, {30'd0, ov8, ir8}, 32'b01);
  endtask

  initial begin
    logic        stable;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;

    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; or8 = 1'b0;

    vecs[0]  = '{4'b1111, 4'b1110, 1'b0, 8'hD2};
    vecs[1]  = '{4'b1111, 4'b1110, 1'b1, 8'h02};
    vecs[2]  = '{4'b1000, 4'b1000, 1'b1, 8'h40};
    vecs[3]  = '{4'b1000, 4'b0111, 1'b1, 8'hC8};
    vecs[4]  = '{4'b0000, 4'b1000, 1'b1, 8'h00};
    vecs[5]  = '{4'd7,    4'd9,    1'b0, 8'h3F};
    vecs[6]  = '{4'd0,    4'd15,   1'b0, 8'h00};
    vecs[7]  = '{4'd15,   4'd15,   1'b0, 8'hE1};
    vecs[8]  = '{4'd7,    4'd7,    1'b1, 8'h31};
    vecs[9]  = '{4'b1111, 4'd7,    1'b1, 8'hF9};
    vecs[10] = '{4'd1,    4'b1111, 1'b1, 8'hFF};
    vecs[11] = '{4'd8,    4'd8,    1'b0, 8'h40};

    tick();
    tick();
    rst_n = 1'b1;
    check("reset_in_ready4", 32'(ir4), 32'd1);
    check("reset_out_valid4", 32'(ov4), 32'd0);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_product4", 32'(p4), 32'd0);
    check("reset_in_ready8", 32'(ir8), 32'd1);
    check("reset_product8", 32'(p8), 32'd0);

    for (int i = 0; i < 12; i++)
      do_op4(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // Backpressure: 3*5 unsigned held for 10 cycles while In_Valid pulses are ignored
    or4 = 1'b0;
    a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_valid", 32'(ov4), 32'd1);
    check("bp_product", 32'(p4), 32'h0F);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv4 = i[0]; a4 = 4'd15; b4 = 4'd15; sm4 = 1'b1;
      tick();
      if (ov4 !== 1'b1 || p4 !== 8'h0F || ir4 !== 1'b0 || busy4 !== 1'b1) stable = 1'b0;
    end
    iv4 = 1'b0;
    check("bp_stable", 32'(stable), 32'd1);
    or4 = 1'b1;
    tick();
    check("bp_handoff", {30'd0, ov4, ir4}, 32'b01);
    tick();
    check("bp_single_handoff", {29'd0, ov4, ir4, busy4}, 32'b010);
    check("bp_product_kept", 32'(p4), 32'h0F);

    // Operand churn while BUSY: 13*11 unsigned = 143
    do_op4(4'd13, 4'd11, 1'b0, 8'h8F, 1'b1, "churn_u");
    // Signed churn: -3 * 5 = -15
    do_op4(4'b1101, 4'd5, 1'b1, 8'hF1, 1'b1, "churn_s");

    // Reset at step 2 of BUSY discards the result
    a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_in_ready", 32'(ir4), 32'd1);
    check("rst_mid_out_valid", 32'(ov4), 32'd0);
    check("rst_mid_busy", 32'(busy4), 32'd0);
    check("rst_mid_product", 32'(p4), 32'd0);
    tick();
    check("rst_mid_idle_hold", {30'd0, ov4, ir4}, 32'b01);
    do_op4(4'd7, 4'd9, 1'b0, 8'h3F, 1'b0, "post_rst");

    // WIDTH=8 directed corners
    do_op8(8'd255, 8'd255, 1'b0, 16'hFE01, 0, "w8_u_max");
    do_op8(8'h80, 8'h80, 1'b1, 16'h4000, 2, "w8_s_min");
    do_op8(8'h80, 8'h7F, 1'b1, 16'hC080, 1, "w8_s_minmax");

    // WIDTH=8 random transactions with random output stalls
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom());
      rb = 8'($urandom());
      rs = 1'($urandom());
      do_op8(ra, rb, rs, ref8(ra, rb, rs), int'($urandom_range(0, 3)), $sformatf("w8_rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
